// File: rtl/tx_arbiter_sequencer_pkg.sv
// Shared types and defaults for the TX arbiter sequencer.
package tx_arbiter_sequencer_pkg;

    localparam int unsigned DEF_LEN_W      = 10;
    localparam int unsigned DEF_WDT_CYCLES = 256;

    typedef enum logic [2:0] {
        NO_SOURCE = 3'd0,
        A2P_1     = 3'd1,
        A2P_2     = 3'd2,
        MASTER    = 3'd3
    } Tx_Arbiter_Sources_t;

    typedef enum logic [2:0] {
        FAILED      = 3'd0,
        SUCCESS_1   = 3'd1,
        SUCCESS_2   = 3'd2,
        SUCCESS_1_2 = 3'd3,
        INVALID     = 3'd4
    } FC_result_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TLP1_HDR  = 3'd1,
        TLP1_DATA = 3'd2,
        TLP2_HDR  = 3'd3,
        TLP2_DATA = 3'd4
    } arbiter_state;

    // True when the verdict lets at least one TLP of the round go out.
    function automatic logic fc_grants(input FC_result_t r);
        return (r == SUCCESS_1) || (r == SUCCESS_2) || (r == SUCCESS_1_2);
    endfunction

endpackage

// File: rtl/tx_arbiter_beat_counter.sv
// Remaining-data-beat counter shared by TLP1 and TLP2: load, decrement, last-beat flag.
module tx_arbiter_beat_counter #(
    parameter int unsigned LEN_W = tx_arbiter_sequencer_pkg::DEF_LEN_W
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_dec,
    output logic             o_last
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    // Saturate at zero so the count can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_len;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_last = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/tx_arbiter_sequencer.sv
// TX arbiter control FSM: acks one decision per round and sequences TLP1 then TLP2 beats.
// Optional stall watchdog is built when TX_ARB_WATCHDOG_EN is defined.
module tx_arbiter_sequencer
    import tx_arbiter_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
`ifdef TX_ARB_WATCHDOG_EN
    , parameter int unsigned WDT_CYCLES = DEF_WDT_CYCLES
`endif
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                i_sel_valid,
    input  Tx_Arbiter_Sources_t i_src1,
    input  Tx_Arbiter_Sources_t i_src2,
    input  logic [LEN_W-1:0]    i_len1,
    input  logic [LEN_W-1:0]    i_len2,
    input  FC_result_t          i_fc_result,
    input  logic                i_buf_ready,
    output logic                o_sel_ack,
    output Tx_Arbiter_Sources_t o_grant,
    output logic                o_rd_en,
    output logic                o_buf_wr,
    output logic                o_sof,
    output logic                o_eof,
    output arbiter_state        o_state,
    output logic                o_stall_err
);

    arbiter_state        state_q, state_d;
    Tx_Arbiter_Sources_t src1_q, src1_d;
    Tx_Arbiter_Sources_t src2_q, src2_d;
    logic [LEN_W-1:0]    len1_q, len1_d;
    logic [LEN_W-1:0]    len2_q, len2_d;
    logic                both_q, both_d;

    logic                beat;
    logic                cnt_load;
    logic [LEN_W-1:0]    cnt_len;
    logic                cnt_dec;
    logic                cnt_last;
    arbiter_state        tlp1_next;

    assign beat      = (state_q != IDLE) && i_buf_ready;
    assign tlp1_next = (both_q && (src2_q != NO_SOURCE)) ? TLP2_HDR : IDLE;

    tx_arbiter_beat_counter #(
        .LEN_W (LEN_W)
    ) u_beat_cnt (
        .clk    (clk),
        .arst   (arst),
        .i_load (cnt_load),
        .i_len  (cnt_len),
        .i_dec  (cnt_dec),
        .o_last (cnt_last)
    );

    // Next-state and beat decode; a beat only moves while the buffer is ready.
    always_comb begin
        state_d   = state_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        len1_d    = len1_q;
        len2_d    = len2_q;
        both_d    = both_q;
        o_sel_ack = 1'b0;
        o_grant   = NO_SOURCE;
        o_sof     = 1'b0;
        o_eof     = 1'b0;
        cnt_load  = 1'b0;
        cnt_len   = '0;
        cnt_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_sel_valid && fc_grants(i_fc_result)) begin
                    o_sel_ack = 1'b1;
                    src1_d    = i_src1;
                    src2_d    = i_src2;
                    len1_d    = i_len1;
                    len2_d    = i_len2;
                    both_d    = (i_fc_result == SUCCESS_1_2);
                    state_d   = (i_fc_result == SUCCESS_2) ? TLP2_HDR : TLP1_HDR;
                end
            end
            TLP1_HDR: begin
                o_grant = src1_q;
                if (beat) begin
                    o_sof = 1'b1;
                    if (len1_q == '0) begin
                        o_eof   = 1'b1;
                        state_d = tlp1_next;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_len  = len1_q;
                        state_d  = TLP1_DATA;
                    end
                end
            end
            TLP1_DATA: begin
                o_grant = src1_q;
                if (beat) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        o_eof   = 1'b1;
                        state_d = tlp1_next;
                    end
                end
            end
            TLP2_HDR: begin
                o_grant = src2_q;
                if (beat) begin
                    o_sof = 1'b1;
                    if (len2_q == '0) begin
                        o_eof   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_len  = len2_q;
                        state_d  = TLP2_DATA;
                    end
                end
            end
            TLP2_DATA: begin
                o_grant = src2_q;
                if (beat) begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        o_eof   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
            src1_q  <= NO_SOURCE;
            src2_q  <= NO_SOURCE;
            len1_q  <= '0;
            len2_q  <= '0;
            both_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            len1_q  <= len1_d;
            len2_q  <= len2_d;
            both_q  <= both_d;
        end
    end

    assign o_rd_en  = beat;
    assign o_buf_wr = beat;
    assign o_state  = state_q;

`ifdef TX_ARB_WATCHDOG_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             stall_err;

    // Counts consecutive stalled cycles of an active TLP; pulses and restarts at the limit.
    always_comb begin
        wdt_d     = wdt_q;
        stall_err = 1'b0;
        if ((state_q == IDLE) || beat) begin
            wdt_d = '0;
        end else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
            stall_err = 1'b1;
            wdt_d     = '0;
        end else begin
            wdt_d = wdt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end

    assign o_stall_err = stall_err;
`else
    assign o_stall_err = 1'b0;
`endif

endmodule

// File: doc/tx_arbiter_sequencer.md
Name: tx_arbiter_sequencer

Overview:
- Control FSM of the TX arbiter. Consumes one arbitration decision per round from the selection/ordering stage: up to two TLP sources plus a flow-control verdict.
- Sequences header and data beats of TLP1 then TLP2 from the granted sources into the TLP buffer.
- Control-only: drives the source read-enables, the buffer write, and the data-mux select. No payload passes through the block.

Parameters:
- LEN_W, 10, width of the per-TLP data-beat count (header excluded); maximum 1023 data beats.
- WDT_CYCLES, 256, stall limit for the watchdog; used only with TX_ARB_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous active-low reset
- i_sel_valid  in  1  selection stage presents a decision
- i_src1  in  3  Tx_Arbiter_Sources_t, source for TLP1
- i_src2  in  3  Tx_Arbiter_Sources_t, source for TLP2 (NO_SOURCE if none)
- i_len1  in  LEN_W  data beats of TLP1 after its header
- i_len2  in  LEN_W  data beats of TLP2 after its header
- i_fc_result  in  3  FC_result_t verdict for this decision
- i_buf_ready  in  1  TLP buffer accepts a beat this cycle
- o_sel_ack  out  1  one-cycle pulse; decision consumed
- o_grant  out  3  Tx_Arbiter_Sources_t, source currently muxed to the buffer
- o_rd_en  out  1  pop one beat from the o_grant source
- o_buf_wr  out  1  write one beat into the TLP buffer
- o_sof  out  1  current beat is a header beat
- o_eof  out  1  current beat is the last beat of a TLP
- o_state  out  3  arbiter_state, for debug
- o_stall_err  out  1  watchdog pulse (tied 0 without the macro)

Behaviour:
- Reset: async on arst=0.
  - State → IDLE; latched src/len/cnt cleared; o_grant=NO_SOURCE.
  - All other outputs 0, including o_stall_err.
  - A reset in any state aborts the TLP in flight. No partial-TLP cleanup is performed; the buffer side discards it.
- States (arbiter_state): IDLE, TLP1_HDR, TLP1_DATA, TLP2_HDR, TLP2_DATA.
- IDLE:
  - If i_sel_valid and i_fc_result ∈ {SUCCESS_1, SUCCESS_1_2}: o_sel_ack=1 (combinational, same cycle); latch src1/src2/len1/len2; next state TLP1_HDR.
  - If i_fc_result = SUCCESS_2: ack, latch, next state TLP2_HDR (TLP1 skipped).
  - FAILED/INVALID, or i_sel_valid=0: stay, no ack.
  - SUCCESS_1 with latched src2 → TLP2 is dropped from this round.
- Beat transfer:
  - In any non-IDLE state, a beat moves in a cycle where i_buf_ready=1.
  - In that cycle o_rd_en = o_buf_wr = 1; both are 0 when ready=0. State and counter hold while ready=0.
- o_grant: latched src1 in TLP1_* states, latched src2 in TLP2_* states, NO_SOURCE in IDLE.
- HDR beat: o_sof=1. If its len=0, o_eof=1 as well. Otherwise cnt ← len and next state is the matching DATA state.
- DATA beat:
  - cnt decrements on each transferred beat.
  - Beat with cnt==1 asserts o_eof and leaves the state.
- After TLP1 ends (HDR with len=0, or final data beat):
  - → TLP2_HDR if the verdict was SUCCESS_1_2 and src2≠NO_SOURCE.
  - → IDLE otherwise.
- After TLP2 ends: → IDLE.
- Minimum one IDLE cycle between rounds; a new decision is never acked in the same cycle as an eof.
- Latency: first header write can occur one cycle after o_sel_ack. Per TLP, throughput is len+1 beats at ready=1.
- Inputs i_src*/i_len* are sampled only in the ack cycle; later changes are ignored.
- Counter never wraps; len=0 never enters a DATA state.

Optional Feature:
- Macro: TX_ARB_WATCHDOG_EN.
- Defined:
  - A counter increments in non-IDLE states while i_buf_ready=0 and clears on any transferred beat or on IDLE.
  - On reaching WDT_CYCLES it pulses o_stall_err for one cycle, then restarts from 0.
  - FSM behaviour is unchanged.
- Undefined: no counter; o_stall_err tied 0.

Decomposition:
- Tx_Arbiter_Package holds: Tx_Arbiter_Sources_t, FC_result_t (widened to 3 bits to hold its five values), arbiter_state, and LEN_W/WDT_CYCLES defaults.
- One natural sub-module: tx_arbiter_beat_counter (load/decrement/last flag), reused for TLP1 and TLP2.
- Watchdog stays inline under the macro.

Test Plan:
- Basic two-TLP round: sel_valid, src1=A2P_1 len1=2, src2=MASTER len2=0, fc=SUCCESS_1_2, ready=1 → ack at t0; writes t1..t4; sof at t1,t4; eof at t3,t4; grant A2P_1 for t1–t3, MASTER at t4; IDLE at t5.
- FC blocked, then succeeds: fc=FAILED for 5 cycles → no ack, no writes. Then fc=SUCCESS_2, src2=A2P_2 len2=1 → only TLP2 written (2 beats); o_grant never shows src1.
- Backpressure: len1=3 with ready toggling 1,0,0,1,1,1 → exactly 4 writes; rd_en==buf_wr every cycle; eof on 4th write only.
- Mid-operation reset: arst low during TLP1_DATA with cnt=5 → outputs 0 immediately. After release, a new decision restarts cleanly from TLP1_HDR.
- Max length with input change: len1=1023, ready=1 → 1024 beats, single eof. Changing i_len1 mid-transfer has no effect.
- Watchdog (macro defined, WDT_CYCLES=8): hold ready=0 in TLP1_HDR → o_stall_err pulses at the 8th and 16th stalled cycles. Undefined macro → stays 0.
